// File: rtl/keyboard_decoder.sv
// keyboard_decoder
// Turns the PS/2 set-2 scancode byte stream into editing commands for
// text_buffer: cursor left/right, backspace, or a 7-bit ASCII symbol.
// Prefix bytes (E0 extended, F0 break) are tracked by a small FSM, both
// shift keys are tracked independently, and each decoded key press is held
// on the registered outputs until text_buffer acknowledges it.

module keyboard_decoder #(
  parameter int SYMBOL_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              scancode,
  input  logic                    scancode_valid,
  output logic                    left,
  output logic                    right,
  output logic                    backspace,
  output logic [SYMBOL_WIDTH-1:0] symbol,
  input  logic                    input_ready
);

  // Prefix FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Prefix and key codes with special meaning
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_BKSP   = 8'h66;
  localparam logic [7:0] CODE_LEFT   = 8'h6B;
  localparam logic [7:0] CODE_RIGHT  = 8'h74;
  localparam logic [7:0] CODE_KP_DIV = 8'h4A;

  logic [1:0]              state_q, state_d;
  logic                    lshift_q, lshift_d;
  logic                    rshift_q, rshift_d;
  logic                    left_q, left_d;
  logic                    right_q, right_d;
  logic                    backspace_q, backspace_d;
  logic [SYMBOL_WIDTH-1:0] symbol_q, symbol_d;

  logic       is_prefix;
  logic       make_stb;
  logic       break_stb;
  logic       is_ext;
  logic       shift;
  logic       pending;
  logic       cmd_valid;
  logic       cmd_left;
  logic       cmd_right;
  logic       cmd_bksp;
  logic [6:0] cmd_ascii;

  // Map a make code to ASCII; 0 means the key has no symbol. Extended
  // codes only carry the keypad divide; the rest are navigation keys.
  function automatic logic [6:0] map_ascii(input logic [7:0] code,
                                           input logic       ext,
                                           input logic       shift_on);
    logic [6:0] a;
    a = 7'h00;
    if (ext) begin
      if (code == CODE_KP_DIV) a = 7'h2F;
    end else begin
      unique case (code)
        // Main-row digits, with the shifted symbols the editor understands
        8'h45: a = shift_on ? 7'h29 : 7'h30;  // ) 0
        8'h16: a = 7'h31;
        8'h1E: a = 7'h32;
        8'h26: a = 7'h33;
        8'h25: a = 7'h34;
        8'h2E: a = 7'h35;
        8'h36: a = shift_on ? 7'h5E : 7'h36;  // ^ 6
        8'h3D: a = 7'h37;
        8'h3E: a = shift_on ? 7'h2A : 7'h38;  // * 8
        8'h46: a = shift_on ? 7'h28 : 7'h39;  // ( 9
        // Operators
        8'h4E: a = 7'h2D;                     // -
        8'h55: a = shift_on ? 7'h2B : 7'h3D;  // + =
        8'h4A: a = 7'h2F;                     // /
        8'h49: a = 7'h2E;                     // .
        // Keypad operators
        8'h79: a = 7'h2B;
        8'h7B: a = 7'h2D;
        8'h7C: a = 7'h2A;
        8'h71: a = 7'h2E;
        // Keypad digits (non-extended 6B/74 are keypad 4/6)
        8'h70: a = 7'h30;
        8'h69: a = 7'h31;
        8'h72: a = 7'h32;
        8'h7A: a = 7'h33;
        8'h6B: a = 7'h34;
        8'h73: a = 7'h35;
        8'h74: a = 7'h36;
        8'h6C: a = 7'h37;
        8'h75: a = 7'h38;
        8'h7D: a = 7'h39;
        // Letters, always lowercase
        8'h1C: a = 7'h61;  // a
        8'h32: a = 7'h62;  // b
        8'h21: a = 7'h63;  // c
        8'h23: a = 7'h64;  // d
        8'h24: a = 7'h65;  // e
        8'h2B: a = 7'h66;  // f
        8'h34: a = 7'h67;  // g
        8'h33: a = 7'h68;  // h
        8'h43: a = 7'h69;  // i
        8'h3B: a = 7'h6A;  // j
        8'h42: a = 7'h6B;  // k
        8'h4B: a = 7'h6C;  // l
        8'h3A: a = 7'h6D;  // m
        8'h31: a = 7'h6E;  // n
        8'h44: a = 7'h6F;  // o
        8'h4D: a = 7'h70;  // p
        8'h15: a = 7'h71;  // q
        8'h2D: a = 7'h72;  // r
        8'h1B: a = 7'h73;  // s
        8'h2C: a = 7'h74;  // t
        8'h3C: a = 7'h75;  // u
        8'h2A: a = 7'h76;  // v
        8'h1D: a = 7'h77;  // w
        8'h22: a = 7'h78;  // x
        8'h35: a = 7'h79;  // y
        8'h1A: a = 7'h7A;  // z
        default: a = 7'h00;
      endcase
    end
    return a;
  endfunction

  // Classify the incoming byte against the current prefix state
  always_comb begin
    // NOTE: every combinationally written signal gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    is_prefix = 1'b0;
    make_stb  = 1'b0;
    break_stb = 1'b0;
    is_ext    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    state_d   = state_q;
    if (scancode_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (scancode == CODE_EXT) begin
            is_prefix = 1'b1;
            state_d   = ST_EXT;
          end else if (scancode == CODE_BRK) begin
            is_prefix = 1'b1;
            state_d   = ST_BRK;
          end else begin
            make_stb = 1'b1;
          end
        end
        ST_EXT: begin
          if (scancode == CODE_BRK) begin
            is_prefix = 1'b1;
            state_d   = ST_EXT_BRK;
          end else begin
            make_stb = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          break_stb = 1'b1;
          state_d   = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shift flags: only non-extended makes/breaks of the two shift keys count
  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    if ((make_stb || break_stb) && !is_ext) begin
      if (scancode == CODE_LSHIFT) lshift_d = make_stb;
      if (scancode == CODE_RSHIFT) rshift_d = make_stb;
    end
  end

  assign shift = lshift_q | rshift_q;

  // Decode a make into at most one command
  always_comb begin
    cmd_left  = 1'b0;
    cmd_right = 1'b0;
    cmd_bksp  = 1'b0;
    cmd_ascii = 7'h00;
    if (make_stb) begin
      if (is_ext && scancode == CODE_LEFT)        cmd_left  = 1'b1;
      else if (is_ext && scancode == CODE_RIGHT)  cmd_right = 1'b1;
      else if (!is_ext && scancode == CODE_BKSP)  cmd_bksp  = 1'b1;
      else                                        cmd_ascii = map_ascii(scancode, is_ext, shift);
    end
  end

  assign cmd_valid = cmd_left | cmd_right | cmd_bksp | (cmd_ascii != 7'h00);
  assign pending   = left_q | right_q | backspace_q | (symbol_q != '0);

  // Hold register: load when free or being acknowledged, drop while busy
  always_comb begin
    left_d      = left_q;
    right_d     = right_q;
    backspace_d = backspace_q;
    symbol_d    = symbol_q;
    if (cmd_valid && (!pending || input_ready)) begin
      left_d      = cmd_left;
      right_d     = cmd_right;
      backspace_d = cmd_bksp;
      symbol_d    = SYMBOL_WIDTH'(cmd_ascii);
    end else if (input_ready) begin
      left_d      = 1'b0;
      right_d     = 1'b0;
      backspace_d = 1'b0;
      symbol_d    = '0;
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      backspace_q <= 1'b0;
      symbol_q    <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      left_q      <= left_d;
      right_q     <= right_d;
      backspace_q <= backspace_d;
      symbol_q    <= symbol_d;
    end
  end

  assign left      = left_q;
  assign right     = right_q;
  assign backspace = backspace_q;
  assign symbol    = symbol_q;

endmodule

// File: doc/keyboard_decoder.md
# keyboard_decoder

Converts the PS/2 set-2 scancode byte stream into the editing commands consumed by `text_buffer`: `left`, `right`, `backspace` and a 7-bit ASCII `symbol`. It sits between the PS/2 byte receiver and `text_buffer`. It tracks make/break and extended prefixes and both shift keys. Each decoded key press is held on its outputs until `text_buffer` acknowledges it with `input_ready`.

## Interface
- `SYMBOL_WIDTH`, 7, width of `symbol`; must match `text_buffer`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `scancode`  in  8  received byte; valid only while `scancode_valid`=1.
- `scancode_valid`  in  1  one-cycle strobe per received byte.
- `left`  out  1  cursor-left command, held until acknowledged.
- `right`  out  1  cursor-right command, held until acknowledged.
- `backspace`  out  1  delete-before-cursor command, held until acknowledged.
- `symbol`  out  SYMBOL_WIDTH  ASCII code to insert; 0 = none; held until acknowledged.
- `input_ready`  in  1  from `text_buffer`; high for one cycle when the held command has been consumed.

## Operation
- Prefix FSM, advanced on each `scancode_valid`:
  - IDLE: 0xE0 → EXT; 0xF0 → BRK; any other byte = non-extended make, → IDLE.
  - EXT: 0xF0 → EXT_BRK; any other byte = extended make, → IDLE.
  - BRK: any byte = non-extended break, → IDLE.
  - EXT_BRK: any byte = extended break, → IDLE.
  - The FSM runs continuously, including while a command is pending.
- Shift tracking:
  - `lshift` is set on make 0x12 and cleared on break 0x12.
  - `rshift` is set on make 0x59 and cleared on break 0x59.
  - shift = `lshift` | `rshift`.
  - Extended 0x12 (fake shift from E0 12) is ignored.
- Break codes affect only the shift flags. Every other break is ignored.
- Make decoding produces at most one command:
  - Extended 0x6B → `left`; extended 0x74 → `right`; non-extended 0x66 → `backspace`.
  - Digits: 0x45 '0', 0x16 '1', 0x1E '2', 0x26 '3', 0x25 '4', 0x2E '5', 0x36 '6', 0x3D '7', 0x3E '8', 0x46 '9'.
  - Shift overrides on digits: shift+0x46 '(', shift+0x45 ')', shift+0x3E '*', shift+0x36 '^'.
  - Operator keys: 0x4E '-', 0x55 '=' (shift → '+'), 0x4A '/', 0x49 '.'.
  - Keypad: 0x79 '+', 0x7B '-', 0x7C '*', extended 0x4A '/', 0x71 '.'. Keypad digits map like the main row (0x70 '0', 0x69 '1', 0x72 '2', 0x7A '3', 0x6B '4', 0x73 '5', 0x74 '6', 0x6C '7', 0x75 '8', 0x7D '9').
  - Letters: set-2 a–z map to lowercase 0x61–0x7A; shift is ignored.
  - Any other make code, including shift makes, produces no command.
- Output hold register, with a `pending` flag equal to the OR of all outputs being non-zero:
  - A decoded command while not pending: load the outputs and set pending.
  - A decoded command while pending with `input_ready`=0: drop it.
  - `input_ready`=1 with no new command: clear all outputs.
  - `input_ready`=1 together with a new decoded command: load the new command instead of clearing.
  - `input_ready` while not pending: ignore it.
- At most one of `left`/`right`/`backspace`/`symbol`≠0 is ever active.
- Typematic repeat (the same make code received again) produces a new command each time.

## Timing
- Reset values: `left`=`right`=`backspace`=0, `symbol`=0, prefix FSM=IDLE, `lshift`=`rshift`=0. The reset applies in any state, including mid-prefix and while pending.
- `rst` has priority over `scancode_valid` and `input_ready` in the same cycle.
- Final byte of a make sequence strobed at edge N → command visible after edge N, i.e. one cycle of latency.
- The command stays stable until `input_ready` is sampled high at edge M, then reads 0 after edge M (unless a new command is loaded at M).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then strobe 0x16 → `symbol`=0x31 one cycle later. Hold 20 cycles with `input_ready`=0: value stays 0x31. Pulse `input_ready` → `symbol`=0 the next cycle.
- Strobe 0x12, 0x46, then 0xF0 0x12, 0x46, each acknowledged → `symbol` sequence '(' then '9'.
- Strobe 0xE0 0x6B → `left`=1; acknowledge. Strobe 0xE0 0xF0 0x6B → no output. Strobe 0x6B (keypad) → `symbol`='4'.
- Assert 0x12 and 0x59 makes, then break 0x12 only, then strobe 0x55 → '+'. Break 0x59, strobe 0x55 → '='.
- With 'x' (0x22) pending, strobe 0x1B → dropped; `symbol` stays 0x78. Strobe 0x66 in the same cycle as `input_ready` → `backspace`=1, `symbol`=0 the next cycle.
- Strobe 0xE0, then assert `rst` → outputs 0. Strobe 0x74 → `symbol`='6', not `right`. An unmapped make 0x05 → no output.
